pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset; SHALL be word-aligned.
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum wait cycles for imem_ack; SHALL be used only when PC_FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 new_pc  input  32  next-PC value from the next-PC logic; SHALL be sampled only on an accepted advance.
REQ-006 advance  input  1  core has finished the current instruction; SHALL be honoured only while instr_valid=1.
REQ-007 pc  output  32  address of the current instruction; this drives old_pc of the next-PC logic.
REQ-008 instr  output  32  current instruction word; this drives instr of the next-PC logic.
REQ-009 instr_valid  output  1  pc/instr hold a fetched instruction.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  32  read address; SHALL equal pc.
REQ-012 imem_rdata  input  32  read data; SHALL be sampled only in the cycle imem_ack=1.
REQ-013 imem_ack  input  1  read complete; SHALL be allowed in the same cycle imem_req rises.
REQ-014 fetch_err  output  1  sticky fault flag.

Function
REQ-015 FSM states: BOOT, FETCH, VALID, ERR; all outputs SHALL be registered or decoded from state only.
REQ-016 BOOT->FETCH unconditionally on the first clock after reset release.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack, instr<=imem_rdata and state->VALID.
REQ-018 Latency: ack in cycle N -> instr_valid=1 with the new instr in cycle N+1.
REQ-019 VALID: instr_valid=1, imem_req=0; advance=1 -> pc<=new_pc, instr_valid=0, state->FETCH in the next cycle.
REQ-020 Zero-wait memory (ack in the same cycle as req) SHALL sustain one instruction every 2 cycles.
REQ-021 imem_ack while imem_req=0 SHALL be ignored; advance while instr_valid=0 SHALL be ignored.
REQ-022 An accepted advance with new_pc[1:0]!=0 SHALL leave pc unchanged, set fetch_err=1, and move to ERR.
REQ-023 ERR: imem_req=0, instr_valid=0, fetch_err=1; the block SHALL stay in ERR until reset.
REQ-024 pc SHALL wrap modulo 2^32; new_pc=32'hFFFF_FFFC SHALL be legal.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0.
REQ-026 Reset asserted mid-fetch SHALL abort the fetch; the first request after release SHALL be to RESET_PC.

Configuration
REQ-027 Macro PC_FETCH_TIMEOUT_EN defined: a wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; reaching TIMEOUT_CYC without ack SHALL set fetch_err=1 and move to ERR.
REQ-028 Macro PC_FETCH_TIMEOUT_EN undefined: no counter SHALL exist, and FETCH SHALL wait indefinitely.

Structure
REQ-029 Shared package seq_pkg SHALL hold WORD_W=32, the fetch state enum, and the default RESET_PC constant.
REQ-030 The timeout counter SHALL be sub-module fetch_watchdog, instantiated only under PC_FETCH_TIMEOUT_EN.

Verification
REQ-031 Reset release, ack same cycle as req, rdata=32'h2001_0005 -> imem_addr=0 at cycle 1, instr_valid=1 with instr=32'h2001_0005 at cycle 2.
REQ-032 In VALID, advance=1 with new_pc=32'h0000_0040 -> next cycle pc=imem_addr=32'h40, imem_req=1, instr_valid=0.
REQ-033 Ack delayed 5 cycles -> imem_req and imem_addr stable for all 5 cycles; exactly one capture.
REQ-034 advance with new_pc=32'h0000_0042 -> fetch_err=1, pc unchanged, no further imem_req until reset.
REQ-035 rst_n pulsed low during a FETCH to 32'h40 -> outputs at reset values immediately; the next request targets RESET_PC.
REQ-036 With PC_FETCH_TIMEOUT_EN defined and TIMEOUT_CYC=8, ack withheld -> fetch_err=1 after 8 FETCH cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction-fetch slice: data width, fetch FSM
// state encoding and the default boot address.
// Optional feature macro used by the importers: PC_FETCH_TIMEOUT_EN.
package seq_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  // True when an address is not on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles that pass without imem_ack; flags expiry on the cycle
// the TIMEOUT_CYC-th ack-less cycle is seen. Only built with PC_FETCH_TIMEOUT_EN.
// Latency: o_expired is combinational from the count and i_tick.
module fetch_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // Count ack-less wait cycles; held at zero whenever the FSM is outside FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // This cycle is the last permitted wait if the count already holds TIMEOUT_CYC-1.
  assign o_expired = i_tick && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pc_fetch.sv
// Program-counter fetch FSM: requests imem at pc, holds the instruction until
// the core advances. Ack in cycle N -> instr_valid in N+1; one instr per 2 cycles
// at zero wait. Backpressure: holds req/addr until ack. Optional: PC_FETCH_TIMEOUT_EN.
module pc_fetch
  import seq_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] new_pc,
  input  logic              advance,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic              fetch_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_instr;
  logic              w_ack_take;
  logic              w_adv_take;
  logic              w_adv_bad;
  logic              w_timeout;

  // An ack only counts while requesting; an advance only counts while holding an instruction.
  assign w_ack_take = (r_state == ST_FETCH) && imem_ack;
  assign w_adv_take = (r_state == ST_VALID) && advance;
  assign w_adv_bad  = w_adv_take && is_misaligned(new_pc);

`ifdef PC_FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state != ST_FETCH),
    .i_tick    ((r_state == ST_FETCH) && !imem_ack),
    .o_expired (w_timeout)
  );
`else
  // Without the watchdog, FETCH waits for as long as the memory takes.
  assign w_timeout = 1'b0;
`endif

  // Next-state decode; ERR is absorbing until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (w_ack_take)     w_state_nxt = ST_VALID;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_VALID: begin
        if (w_adv_bad)       w_state_nxt = ST_ERR;
        else if (w_adv_take) w_state_nxt = ST_FETCH;
      end
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // PC only moves on an accepted, word-aligned advance; a bad target leaves it pointing at the faulting instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_pc <= RESET_PC;
    else if (w_adv_take && !w_adv_bad) r_pc <= new_pc;
  end

  // Capture the read data exactly once, in the ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_instr <= '0;
    else if (w_ack_take) r_instr <= imem_rdata;
  end

  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_VALID);
  assign fetch_err   = (r_state == ST_ERR);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, zero-wait fetch, advance, delayed ack,
// misaligned target, mid-fetch reset and the optional watchdog.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] new_pc;
  logic        advance;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  pc_fetch #(
    .RESET_PC    (32'h0000_0000),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_pc      (new_pc),
    .advance     (advance),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release just after an edge: that cycle is BOOT.
  task automatic do_reset();
    rst_n      = 1'b0;
    advance    = 1'b0;
    imem_ack   = 1'b0;
    new_pc     = 32'h0;
    imem_rdata = 32'h0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    advance    = 1'b0;
    imem_ack   = 1'b0;
    new_pc     = 32'h0;
    imem_rdata = 32'h0;
    #1;
    checks++;
    if ({imem_req, instr_valid, fetch_err} !== 3'b000 || pc !== 32'h0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b vld=%b err=%b pc=%h instr=%h, want 0 0 0 0 0",
               imem_req, instr_valid, fetch_err, pc, instr);
    end
    step();
  endtask

  task automatic test_zero_wait();
    do_reset();
    step();  // cycle 1: FETCH
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h vld=%b, want 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h2001_0005;
    step();  // cycle 2: VALID
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h2001_0005 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_capture: vld=%b instr=%h req=%b, want 1 20010005 0", instr_valid, instr, imem_req);
    end
    // Stray ack while not requesting must not overwrite instr.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++;
    if (instr !== 32'h2001_0005 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL stray_ack: instr=%h vld=%b, want 20010005 1", instr, instr_valid);
    end
  endtask

  task automatic test_advance();
    advance = 1'b1;
    new_pc  = 32'h0000_0040;
    step();
    advance = 1'b0;
    checks++;
    if (pc !== 32'h40 || imem_addr !== 32'h40 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL advance: pc=%h addr=%h req=%b vld=%b, want 40 40 1 0", pc, imem_addr, imem_req, instr_valid);
    end
  endtask

  task automatic test_delayed_ack();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'h1000_0000 + i;
      step();
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL delayed_hold: %0d unstable cycles, want 0", bad);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hCAFE_0002;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL delayed_capture: vld=%b instr=%h, want 1 cafe0001", instr_valid, instr);
    end
    step();
    checks++;
    if (instr !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL single_capture: instr=%h, want cafe0001", instr);
    end
  endtask

  task automatic test_back_to_back();
    // From VALID at pc=0x40: advance to 0x80 with zero-wait memory.
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_0080;
    advance    = 1'b1;
    new_pc     = 32'h0000_0080;
    step();  // FETCH 0x80; advance here must be ignored
    new_pc     = 32'h0000_0200;
    checks++;
    if (imem_req !== 1'b1 || pc !== 32'h80) begin
      errors++;
      $display("FAIL b2b_fetch: req=%b pc=%h, want 1 80", imem_req, pc);
    end
    step();  // VALID
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hAAAA_0080 || pc !== 32'h80) begin
      errors++;
      $display("FAIL b2b_valid: vld=%b instr=%h pc=%h, want 1 aaaa0080 80", instr_valid, instr, pc);
    end
    new_pc     = 32'hFFFF_FFFC;
    imem_rdata = 32'hBBBB_FFFC;
    step();  // FETCH top-of-memory
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL top_addr: req=%b addr=%h err=%b, want 1 fffffffc 0", imem_req, imem_addr, fetch_err);
    end
    advance = 1'b0;
    step();  // VALID
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hBBBB_FFFC) begin
      errors++;
      $display("FAIL top_capture: vld=%b instr=%h, want 1 bbbbfffc", instr_valid, instr);
    end
  endtask

  task automatic test_misaligned();
    int bad = 0;
    advance = 1'b1;
    new_pc  = 32'h0000_0042;
    step();
    checks++;
    if (fetch_err !== 1'b1 || pc !== 32'hFFFF_FFFC || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL misaligned: err=%b pc=%h req=%b vld=%b, want 1 fffffffc 0 0",
               fetch_err, pc, imem_req, instr_valid);
    end
    new_pc   = 32'h0000_0100;
    imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) bad++;
    end
    advance  = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL err_sticky: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    advance  = 1'b1;
    new_pc   = 32'h0000_0040;
    step();
    advance = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL pre_abort: req=%b addr=%h, want 1 40", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h instr=%h vld=%b err=%b, want 0 0 0 0 0",
               imem_req, pc, instr, instr_valid, fetch_err);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL refetch_reset_pc: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step();  // first FETCH cycle
`ifdef PC_FETCH_TIMEOUT_EN
    for (int i = 0; i < 7; i++) step();  // FETCH cycles 2..8
    checks++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: req=%b err=%b, want 1 0", imem_req, fetch_err);
    end
    step();
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: err=%b req=%b, want 1 0", fetch_err, imem_req);
    end
`else
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wait_forever: req=%b err=%b addr=%h, want 1 0 0", imem_req, fetch_err, imem_addr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_advance();
    test_delayed_ack();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_fetch();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
